// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate extender: mode encoding and its type.
package imm_ext_pkg;

    typedef logic [1:0] imm_mode_t;

    localparam imm_mode_t MODE_SIGN    = 2'b00;
    localparam imm_mode_t MODE_ZERO    = 2'b01;
    localparam imm_mode_t MODE_UPPER   = 2'b10;
    localparam imm_mode_t MODE_SUBSIGN = 2'b11;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extension: {imm, mode} -> OUT_W-bit result.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned SUB_W = 8
) (
    input  logic [IN_W-1:0]  imm,
    input  imm_mode_t        mode,
    output logic [OUT_W-1:0] data
);

    localparam int unsigned EXT_W     = OUT_W - IN_W;
    localparam int unsigned SUB_EXT_W = OUT_W - SUB_W;

    // Select the extension flavour; SUBSIGN ignores imm bits above SUB_W-1.
    always_comb begin
        data = '0;
        case (mode)
            MODE_SIGN:    data = {{EXT_W{imm[IN_W-1]}}, imm};
            MODE_ZERO:    data = {{EXT_W{1'b0}}, imm};
            MODE_UPPER:   data = {imm, {EXT_W{1'b0}}};
            MODE_SUBSIGN: data = {{SUB_EXT_W{imm[SUB_W-1]}}, imm[SUB_W-1:0]};
            default:      data = '0;
        endcase
    end

endmodule

// File: rtl/imm_extend_unit.sv
// Pipelined immediate extender: combinational extension feeding a 2-entry
// output FIFO with valid/ready on both sides and a synchronous flush.
module imm_extend_unit
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned SUB_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  imm_mode_t        in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [1:0]       out_count
);

    logic [OUT_W-1:0] ext_data;
    logic [OUT_W-1:0] mem_q [2];
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             push;
    logic             pop;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SUB_W (SUB_W)
    ) u_core (
        .imm  (in_imm),
        .mode (in_mode),
        .data (ext_data)
    );

    // Handshake flags come only from registered state, so no input->output path.
    always_comb begin
        in_ready  = (count_q < 2'd2);
        out_valid = (count_q != 2'd0);
        out_data  = mem_q[rd_ptr_q];
        out_count = count_q;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Occupancy update; simultaneous push and pop leaves count unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Buffer state; reset clears storage too, flush only empties the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= ext_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_imm_extend_unit.sv
// Self-checking bench for imm_extend_unit: vector table plus directed sequences.
module tb_imm_extend_unit;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_count;

    logic        w_in_valid;
    logic        w_in_ready;
    logic [11:0] w_in_imm;
    logic [1:0]  w_in_mode;
    logic        w_out_valid;
    logic [63:0] w_out_data;
    logic [1:0]  w_out_count;

    int tests;
    int fails;

    imm_extend_unit #(
        .IN_W  (16),
        .OUT_W (32),
        .SUB_W (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    imm_extend_unit #(
        .IN_W  (12),
        .OUT_W (64),
        .SUB_W (4)
    ) dut_wide (
        .clk       (clk),
        .reset     (reset),
        .flush     (1'b0),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .in_imm    (w_in_imm),
        .in_mode   (w_in_mode),
        .out_valid (w_out_valid),
        .out_ready (1'b1),
        .out_data  (w_out_data),
        .out_count (w_out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] imm;
        logic [1:0]  mode;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [11:0] imm;
        logic [1:0]  mode;
        logic [63:0] exp;
    } wvec_t;

    vec_t  vecs  [10];
    wvec_t wvecs [3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_imm = '0;
        in_mode = 2'b00;
        out_ready = 1'b1;
        w_in_valid = 1'b0;
        w_in_imm = '0;
        w_in_mode = 2'b00;

        vecs[0] = '{16'h8001, 2'b00, 32'hFFFF8001};
        vecs[1] = '{16'h8001, 2'b01, 32'h00008001};
        vecs[2] = '{16'h8001, 2'b10, 32'h80010000};
        vecs[3] = '{16'h8001, 2'b11, 32'h00000001};
        vecs[4] = '{16'h0080, 2'b00, 32'h00000080};
        vecs[5] = '{16'h0080, 2'b01, 32'h00000080};
        vecs[6] = '{16'h0080, 2'b10, 32'h00800000};
        vecs[7] = '{16'h0080, 2'b11, 32'hFFFFFF80};
        vecs[8] = '{16'h7FFF, 2'b00, 32'h00007FFF};
        vecs[9] = '{16'hFF7F, 2'b11, 32'h0000007F};

        wvecs[0] = '{12'h800, 2'b00, 64'hFFFFFFFFFFFFF800};
        wvecs[1] = '{12'h0F8, 2'b11, 64'hFFFFFFFFFFFFFFF8};
        wvecs[2] = '{12'hABC, 2'b10, 64'hABC0000000000000};

        // 1. Reset
        tick();
        tick();
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_count", {62'd0, out_count}, 64'd0);
        check("rst_data", {32'd0, out_data}, 64'd0);
        reset = 1'b0;
        tick();

        // 2. Extension modes, one push per vector with out_ready high
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_imm   = vecs[i].imm;
            in_mode  = vecs[i].mode;
            tick();
            in_valid = 1'b0;
            in_mode  = ~vecs[i].mode;  // mode changes after push must not matter
            check($sformatf("vec%0d_valid", i), {63'd0, out_valid}, 64'd1);
            check($sformatf("vec%0d_data", i), {32'd0, out_data}, {32'd0, vecs[i].exp});
            tick();
            check($sformatf("vec%0d_drain", i), {63'd0, out_valid}, 64'd0);
        end

        // 3. Back-pressure and ordering, third push held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'b00;
        in_imm    = 16'h1234;
        tick();
        in_imm = 16'hFFFE;
        tick();
        check("bp_count2", {62'd0, out_count}, 64'd2);
        check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        in_imm  = 16'h5555;
        in_mode = 2'b01;
        tick();
        check("bp_held_count", {62'd0, out_count}, 64'd2);
        check("bp_head_stable", {32'd0, out_data}, 64'h00001234);
        out_ready = 1'b1;
        tick();
        check("bp_second", {32'd0, out_data}, 64'hFFFFFFFE);
        check("bp_count1", {62'd0, out_count}, 64'd1);
        tick();
        in_valid = 1'b0;
        check("bp_third", {32'd0, out_data}, 64'h00005555);
        check("bp_pushpop_count", {62'd0, out_count}, 64'd1);
        tick();
        check("bp_empty", {63'd0, out_valid}, 64'd0);

        // 4. Streaming
        in_mode = 2'b00;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_imm   = 16'h0010 + 16'(i);
            tick();
            check($sformatf("st%0d_valid", i), {63'd0, out_valid}, 64'd1);
            check($sformatf("st%0d_data", i), {32'd0, out_data}, 64'h10 + 64'(i));
            check($sformatf("st%0d_count", i), {62'd0, out_count}, 64'd1);
        end
        in_valid = 1'b0;
        tick();
        check("st_drain", {63'd0, out_valid}, 64'd0);

        // 5a. Flush at count 2 with concurrent push attempt
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_imm    = 16'hAAAA;
        tick();
        in_imm = 16'hBBBB;
        tick();
        check("fl_count2", {62'd0, out_count}, 64'd2);
        flush  = 1'b1;
        in_imm = 16'hCCCC;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_count0", {62'd0, out_count}, 64'd0);
        check("fl_valid0", {63'd0, out_valid}, 64'd0);
        check("fl_in_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        tick();
        check("fl_no_ghost", {63'd0, out_valid}, 64'd0);

        // 5b. Flush at count 1 drops the concurrent push
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_imm    = 16'h1111;
        tick();
        flush  = 1'b1;
        in_imm = 16'h2222;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl1_count0", {62'd0, out_count}, 64'd0);
        tick();
        check("fl1_no_push", {63'd0, out_valid}, 64'd0);
        out_ready = 1'b1;

        // 6. Reset at count 1 with in_valid high
        in_valid = 1'b1;
        in_imm   = 16'h4321;
        tick();
        check("rs_count1", {62'd0, out_count}, 64'd1);
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        check("rs_valid0", {63'd0, out_valid}, 64'd0);
        check("rs_in_ready", {63'd0, in_ready}, 64'd1);
        check("rs_data0", {32'd0, out_data}, 64'd0);

        // Parameter sweep: IN_W=12, OUT_W=64, SUB_W=4
        for (int i = 0; i < 3; i++) begin
            w_in_valid = 1'b1;
            w_in_imm   = wvecs[i].imm;
            w_in_mode  = wvecs[i].mode;
            tick();
            w_in_valid = 1'b0;
            check($sformatf("wide%0d_valid", i), {63'd0, w_out_valid}, 64'd1);
            check($sformatf("wide%0d_data", i), w_out_data, wvecs[i].exp);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
